parking_access_arbiter: RTL

Arbitration and sequencing controller for the shared occupancy counter in the vehicle parking design. It latches one-cycle entry and exit requests from the two lane detectors, grants one lane at a time with round-robin fairness, and enforces the lot capacity and empty limits. It issues mutually exclusive `inc`/`dec` pulses to the binary counter and holds each lane's barrier open for a fixed window.

---
 rtl/parking_access_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/parking_access_arbiter.sv
// -----------------------------------------------------------------------------
// parking_access_arbiter
//
// Purpose:
//   Sequencing controller for the shared occupancy counter of the parking
//   lot. It latches one-cycle entry/exit request pulses from the two lane
//   detectors and serves one lane at a time, alternating lanes when both are
//   waiting. It refuses entries when the lot is full and exits when it is
//   empty. For every granted request it emits a single inc/dec pulse to the
//   external counter and holds that lane's barrier open for HOLD_CYCLES
//   cycles.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   entry_req     in   one-cycle pulse, vehicle at entry lane
//   exit_req      in   one-cycle pulse, vehicle at exit lane
//   count         in   current occupancy (updates the cycle after inc/dec)
//   inc           out  one-cycle increment pulse to the counter
//   dec           out  one-cycle decrement pulse to the counter
//   entry_gate    out  entry barrier open (level)
//   exit_gate     out  exit barrier open (level)
//   entry_denied  out  one-cycle pulse, entry refused (lot full)
//   exit_denied   out  one-cycle pulse, exit refused (lot empty)
//   req_overrun   out  one-cycle pulse, a request hit an already-pending lane
//   full          out  combinational, count >= CAPACITY
//   empty         out  combinational, count == 0
//   busy          out  controller is not idle
// -----------------------------------------------------------------------------
module parking_access_arbiter #(
    parameter int CAPACITY    = 99,
    parameter int CNT_W       = 7,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic [CNT_W-1:0] count,
    output logic             inc,
    output logic             dec,
    output logic             entry_gate,
    output logic             exit_gate,
    output logic             entry_denied,
    output logic             exit_denied,
    output logic             req_overrun,
    output logic             full,
    output logic             empty,
    output logic             busy
);

    // HOLD_CYCLES >= 2, so HOLD_CYCLES-1 always fits in clog2(HOLD_CYCLES) bits.
    localparam int               TMR_W    = $clog2(HOLD_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);

    // Lane encoding, also used as the index into the pending vector.
    localparam logic LANE_EN = 1'b0;
    localparam logic LANE_EX = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT_EN,
        S_GRANT_EX,
        S_DENY_EN,
        S_DENY_EX,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_pend;
    logic [1:0]       w_pend_next;
    logic [1:0]       w_req;
    logic [1:0]       w_clr;
    logic [1:0]       w_drop;
    logic             r_last_served;
    logic             r_lane;
    logic [TMR_W-1:0] r_timer;
    logic             r_overrun;
    logic             w_sel;

    assign full  = (count >= CAP_V);
    assign empty = (count == '0);

    assign w_req = {exit_req, entry_req};

    // A lane's pending flag is consumed in the cycle its grant or deny state
    // is active, not when IDLE picks it, so a request arriving in that same
    // cycle is still kept.
    assign w_clr[LANE_EN] = (r_state == S_GRANT_EN) || (r_state == S_DENY_EN);
    assign w_clr[LANE_EX] = (r_state == S_GRANT_EX) || (r_state == S_DENY_EX);

    // Per-lane pending bookkeeping: set beats clear; a request landing on a
    // flag that is set and not being consumed is lost and reported.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign w_drop[gi]      = w_req[gi] & r_pend[gi] & ~w_clr[gi];
            assign w_pend_next[gi] = w_req[gi] | (r_pend[gi] & ~w_clr[gi]);
        end
    endgenerate

    // With both lanes waiting, serve the one that did not go last;
    // otherwise serve whichever lane is pending (entry when only it is).
    assign w_sel = (r_pend == 2'b11) ? ~r_last_served : r_pend[LANE_EX];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pending flags, served-lane history, hold timer and overrun pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend        <= 2'b00;
            r_last_served <= LANE_EX;
            r_lane        <= LANE_EN;
            r_timer       <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_pend    <= w_pend_next;
            r_overrun <= |w_drop;
            case (r_state)
                S_GRANT_EN: begin
                    r_timer       <= TMR_LOAD;
                    r_lane        <= LANE_EN;
                    r_last_served <= LANE_EN;
                end
                S_GRANT_EX: begin
                    r_timer       <= TMR_LOAD;
                    r_lane        <= LANE_EX;
                    r_last_served <= LANE_EX;
                end
                S_DENY_EN: r_last_served <= LANE_EN;
                S_DENY_EX: r_last_served <= LANE_EX;
                S_HOLD:    r_timer       <= r_timer - TMR_ONE;
                default:   ;
            endcase
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        w_state_next = r_state;
        inc          = 1'b0;
        dec          = 1'b0;
        entry_gate   = 1'b0;
        exit_gate    = 1'b0;
        entry_denied = 1'b0;
        exit_denied  = 1'b0;
        busy         = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (r_pend != 2'b00) begin
                    if (w_sel == LANE_EN) begin
                        w_state_next = full ? S_DENY_EN : S_GRANT_EN;
                    end else begin
                        w_state_next = empty ? S_DENY_EX : S_GRANT_EX;
                    end
                end
            end
            S_GRANT_EN: begin
                inc          = 1'b1;
                entry_gate   = 1'b1;
                w_state_next = S_HOLD;
            end
            S_GRANT_EX: begin
                dec          = 1'b1;
                exit_gate    = 1'b1;
                w_state_next = S_HOLD;
            end
            S_DENY_EN: begin
                entry_denied = 1'b1;
                w_state_next = S_IDLE;
            end
            S_DENY_EX: begin
                exit_denied  = 1'b1;
                w_state_next = S_IDLE;
            end
            S_HOLD: begin
                entry_gate = (r_lane == LANE_EN);
                exit_gate  = (r_lane == LANE_EX);
                // The grant cycle plus HOLD_CYCLES-1 hold cycles give a gate
                // window of exactly HOLD_CYCLES.
                if (r_timer == TMR_ONE) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign req_overrun = r_overrun;

endmodule
